// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Types and constants shared by the RISC-V fetch front end.
//   XLEN          : architectural register / address width
//   NOP_INST      : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   fetch_state_e : fetch sequencer states
//   fetch_entry_t : one queued instruction together with the PC it came from
//   word_align    : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO of fetch_entry_t. The head entry is visible
//   combinationally so decode sees it in the same cycle it becomes valid.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous, active-low reset
//     clear      in   drop all entries (takes priority over push/pop)
//     push       in   write push_entry at the tail
//     push_entry in   entry to write
//     pop        in   retire the head entry (caller only pops when count!=0)
//     count      out  number of valid entries, 0..DEPTH
//     head       out  oldest entry (undefined when count==0)
// ---------------------------------------------------------------------------
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    fetch_entry_t  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by count_reg alone.
    // On a full push+pop the write lands on the slot being popped, which
    // has already been read out combinationally this cycle.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    // The issue credit must keep the queue from ever overflowing.
    always_ff @(posedge clk) begin
        if (reset && !clear) begin
            assert (!(push && !pop && (count_reg == FULL_CNT)));
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   Fetch stage of the RISC-V pipeline. Owns the fetch PC, issues word reads
//   to instruction memory, tracks in-flight reads, queues returned words with
//   their PC and hands them to decode over a valid/ready handshake. A
//   redirect from EX flushes the queue and discards stale in-flight reads.
//   Ports:
//     clk             in   clock, rising edge
//     reset           in   asynchronous, active-low reset
//     imem_req_valid  out  fetch request valid
//     imem_req_ready  in   memory accepts request this cycle
//     imem_req_addr   out  word address of request ([1:0]=0)
//     imem_rsp_valid  in   in-order response, never back-pressured
//     imem_rsp_data   in   instruction word
//     redirect_valid  in   single-cycle redirect pulse from EX
//     redirect_pc     in   redirect target ([1:0] ignored)
//     dec_valid       out  dec_inst/dec_pc valid
//     dec_ready       in   decode consumes head entry
//     dec_inst        out  head instruction, NOP when queue empty
//     dec_pc          out  head PC, 0 when queue empty
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    fetch_state_e    state_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] rsp_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   drop_cnt_next;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;

    logic [XLEN-1:0] redirect_target;
    logic            credit_ok;
    logic            queue_nonempty;
    logic            req_fire;
    logic            rsp_push;
    logic            fifo_pop;

    assign redirect_target = word_align(redirect_pc);
    assign queue_nonempty  = (fifo_count != '0);

    // Queued entries plus reads still in flight may never exceed the queue
    // depth, so every response is guaranteed a free slot when it returns.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_reg}) < CREDIT_LIMIT;

    assign imem_req_valid = (state_reg == RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when nothing stale is ahead of it and no
    // redirect is flushing the queue in the same cycle.
    assign rsp_push   = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
    assign push_entry = '{inst: imem_rsp_data, pc: rsp_pc_reg};

    assign dec_valid = queue_nonempty && !redirect_valid;
    assign fifo_pop  = dec_valid && dec_ready;
    assign dec_inst  = queue_nonempty ? fifo_head.inst : NOP_INST;
    assign dec_pc    = queue_nonempty ? fifo_head.pc   : '0;

    // outstanding counts every accepted read not yet answered, stale or not.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    // On a redirect every read still in flight after this cycle is stale.
    // No request can be accepted in a redirect cycle, so that set is exactly
    // outstanding_next (a response arriving now has already been dropped).
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (redirect_valid) begin
            drop_cnt_next = outstanding_next;
        end else if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= BOOT;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    if (redirect_valid && (drop_cnt_next != '0)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drop_cnt_next == '0) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            if (redirect_valid) begin
                fetch_pc_reg <= redirect_target;
                rsp_pc_reg   <= redirect_target;
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (rsp_push) begin
                    rsp_pc_reg <= rsp_pc_reg + 32'd4;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .push       (rsp_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .count      (fifo_count),
        .head       (fifo_head)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Randomized bench for instr_fetch_queue. A memory model answers accepted
//   reads in order after a random latency. The reference model tags every
//   in-flight read with a redirect epoch: reads from an older epoch are
//   stale and must be discarded, reads from the current epoch land in a
//   decode queue in order. Outputs are compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc)
    );

    typedef struct { logic [31:0] addr; int unsigned due;   } mem_req_t;
    typedef struct { logic [31:0] addr; int unsigned epoch; } flight_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc;    } dec_t;

    mem_req_t    memq[$];
    flight_t     infl[$];
    dec_t        decq[$];
    logic [31:0] acc_log[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned epoch = 0;
    logic [31:0] exp_fetch = RST_PC;
    bit          boot = 1'b1;
    bit          nxt_rsp_valid = 1'b0;
    logic [31:0] nxt_rsp_addr = '0;

    // stimulus knobs (written only by the main process)
    int          lat_min = 1;
    int          lat_max = 1;
    int          p_ready = 100;
    int          p_dec = 100;
    int          p_redir = 0;
    bit          redir_req = 1'b0;
    bit          redir_on_rsp = 1'b0;
    logic [31:0] redir_target = '0;
    bit          verbose = 1'b0;
    int          acc_base = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [31:0] exp);
        if (acc_log.size() > acc_base + idx) begin
            chk(name, acc_log[acc_base + idx], exp);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: only %0d requests seen, expected addr %08h at index %0d",
                     name, acc_log.size() - acc_base, exp, idx);
        end
    endtask

    // ---------------- compare process + reference model ----------------
    always @(negedge clk) begin
        int      stale;
        bit      exp_rv;
        bit      exp_dv;
        flight_t f;
        if (!reset) begin
            chk("rst_req_valid", imem_req_valid, 1'b0);
            chk("rst_req_addr", imem_req_addr, RST_PC);
            chk("rst_dec_valid", dec_valid, 1'b0);
            chk("rst_dec_inst", dec_inst, NOP);
            chk("rst_dec_pc", dec_pc, 32'h0);
            decq.delete();
            infl.delete();
            memq.delete();
            epoch = 0;
            exp_fetch = RST_PC;
            boot = 1'b1;
            nxt_rsp_valid = 1'b0;
        end else begin
            stale = 0;
            foreach (infl[i]) if (infl[i].epoch != epoch) stale++;
            exp_rv = !boot && !redirect_valid && (stale == 0) &&
                     (decq.size() + infl.size() < DEPTH);
            exp_dv = (decq.size() != 0) && !redirect_valid;

            chk("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) chk("req_addr", imem_req_addr, exp_fetch);
            chk("dec_valid", dec_valid, exp_dv);
            if (decq.size() != 0) begin
                chk("dec_inst", dec_inst, decq[0].inst);
                chk("dec_pc", dec_pc, decq[0].pc);
            end else begin
                chk("idle_dec_inst", dec_inst, NOP);
                chk("idle_dec_pc", dec_pc, 32'h0);
            end

            if (exp_dv && dec_ready) begin
                if (verbose) $display("decode pc=%08h inst=%08h", decq[0].pc, decq[0].inst);
                void'(decq.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                acc_log.push_back(imem_req_addr);
                infl.push_back('{addr: exp_fetch, epoch: epoch});
                memq.push_back('{addr: imem_req_addr,
                                 due: cyc + $urandom_range(lat_max, lat_min)});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (imem_rsp_valid && infl.size() != 0) begin
                f = infl.pop_front();
                if (!redirect_valid && f.epoch == epoch)
                    decq.push_back('{inst: mem_word(f.addr), pc: f.addr});
            end
            if (redirect_valid) begin
                decq.delete();
                epoch++;
                exp_fetch = {redirect_pc[31:2], 2'b00};
            end
            boot = 1'b0;
        end
        cyc++;
        // memory decides its response for the coming cycle
        nxt_rsp_valid = 1'b0;
        if (reset && memq.size() != 0 && memq[0].due <= cyc) begin
            nxt_rsp_valid = 1'b1;
            nxt_rsp_addr = memq[0].addr;
            void'(memq.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle_drive();
        @(posedge clk);
        #1;
        imem_rsp_valid = nxt_rsp_valid;
        imem_rsp_data  = nxt_rsp_valid ? mem_word(nxt_rsp_addr) : $urandom;
        imem_req_ready = ($urandom_range(99) < p_ready);
        dec_ready      = ($urandom_range(99) < p_dec);
        if (redir_req || (redir_on_rsp && imem_rsp_valid)) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            redir_req      = 1'b0;
            redir_on_rsp   = 1'b0;
            acc_base       = acc_log.size();
            if (verbose) $display("redirect to %08h", redir_target);
        end else if ($urandom_range(999) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        acc_base = acc_log.size();
    endtask

    task automatic set_mode(input int lmin, input int lmax, input int pr, input int pd);
        lat_min = lmin;
        lat_max = lmax;
        p_ready = pr;
        p_dec   = pd;
        p_redir = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        verbose = 1'b1;

        // 1: streaming fetch with single-cycle memory
        set_mode(1, 1, 100, 100);
        do_reset();
        run(12);
        chk_acc("t1_addr0", 0, 32'h0);
        chk_acc("t1_addr1", 1, 32'h4);
        chk_acc("t1_addr2", 2, 32'h8);
        chk_acc("t1_addr3", 3, 32'hC);

        // 2: decode stalled -> exactly DEPTH requests, then issue stops
        set_mode(1, 1, 100, 0);
        do_reset();
        run(10);
        @(negedge clk);
        chk("t2_num_reqs", acc_log.size() - acc_base, 32'd4);
        chk_acc("t2_last_addr", 3, 32'hC);
        chk("t2_stalled", imem_req_valid, 1'b0);
        chk("t2_head_pc", dec_pc, 32'h0);
        chk("t2_head_inst", dec_inst, 32'hC0DE_0013);
        p_dec = 100;
        run(10);

        // 3: 3-cycle memory, redirect with two reads in flight
        set_mode(3, 3, 100, 100);
        do_reset();
        run(2);
        redir_target = 32'h100;
        redir_req = 1'b1;
        run(1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle_drive();
            @(negedge clk);
            seen = dec_valid;
        end
        if (seen) begin
            chk("t3_first_pc", dec_pc, 32'h100);
            chk("t3_first_inst", dec_inst, 32'hC1DE_0013);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL t3_timeout: got no dec_valid expected dec_valid within 30 cycles");
        end
        chk_acc("t3_req_addr", 0, 32'h100);

        // 4: redirect coinciding with a response
        set_mode(2, 2, 100, 100);
        do_reset();
        run(4);
        redir_target = 32'h100;
        redir_on_rsp = 1'b1;
        run(12);
        chk("t4_fired", redir_on_rsp, 1'b0);
        chk_acc("t4_req_addr", 0, 32'h100);

        // 5: address wrap and unaligned redirect target
        set_mode(1, 1, 100, 100);
        redir_target = 32'hFFFF_FFF8;
        redir_req = 1'b1;
        run(12);
        chk_acc("t5_addr0", 0, 32'hFFFF_FFF8);
        chk_acc("t5_addr1", 1, 32'hFFFF_FFFC);
        chk_acc("t5_wrap", 2, 32'h0000_0000);
        redir_target = 32'h203;
        redir_req = 1'b1;
        run(8);
        chk_acc("t5_align", 0, 32'h200);

        // 6: reset while draining stale responses
        set_mode(3, 3, 100, 100);
        run(3);
        redir_target = 32'h40;
        redir_req = 1'b1;
        run(1);
        do_reset();
        run(6);
        chk_acc("t6_after_reset", 0, RST_PC);

        // random traffic
        verbose = 1'b0;
        set_mode(1, 4, 70, 60);
        p_redir = 20;
        run(3000);
        set_mode(1, 6, 50, 80);
        p_redir = 80;
        run(3000);
        set_mode(1, 3, 90, 30);
        p_redir = 10;
        run(2000);
        p_redir = 0;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
